// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period arithmetic and frame lengths.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } uart_state_e;

  localparam int unsigned FrameBitsNoParity = 10;
  localparam int unsigned FrameBitsParity   = 11;

  // Clock cycles per bit, truncated toward zero.
  function automatic int unsigned uart_rate(input int unsigned clock_rate,
                                            input int unsigned baud_rate);
    return clock_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..RATE-1 and pulses tick on the last count.
module uart_baud_gen #(
  parameter int unsigned RATE = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = $clog2(RATE) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RATE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  // Clearing on accept phase-aligns every bit boundary to the accept edge.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input.
// Define UART_TX_PARITY_EN to compile in the optional even-parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 100000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned PARITY     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned Rate = uart_rate(CLOCK_RATE, BAUD_RATE);

`ifdef UART_TX_PARITY_EN
  localparam bit ParityOn = (PARITY != 0);
  logic parity_q, parity_d;
`else
  localparam bit unused_parity = (PARITY != 0);
`endif

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        tick;

  assign ready  = (state_q == StIdle);
  assign accept = valid && ready;
  assign tx     = tx_q;
  assign busy   = busy_q;

  uart_baud_gen #(
    .RATE (Rate)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .tick  (tick)
  );

  // tx is registered from the current state, so the line lags the state by one cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = 1'b1;
    busy_d  = (state_q != StIdle);
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = data;
          idx_d   = '0;
          state_d = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data;
`endif
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (tick) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ParityOn ? StParity : StStop;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        tx_d = parity_q;
        if (tick) begin
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor decodes tx.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int unsigned ClockRate = 1000000;
  localparam int unsigned BaudRate  = 100000;
  localparam int unsigned Parity    = 1;
  localparam int          Rate      = 10;

`ifdef UART_TX_PARITY_EN
  localparam bit HasPar = (Parity != 0);
  localparam int NBits  = (Parity != 0) ? int'(FrameBitsParity) : int'(FrameBitsNoParity);
`else
  localparam bit HasPar = 1'b0;
  localparam int NBits  = int'(FrameBitsNoParity);
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       tx;
  logic       busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  d;
    logic        p;
    int          acc;
    bit          abort;
    logic [10:0] frame;
  } exp_t;

  exp_t sb[$];
  bit   mon_active = 1'b0;

  uart_tx #(
    .CLOCK_RATE (ClockRate),
    .BAUD_RATE  (BaudRate),
    .PARITY     (Parity)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .data  (data),
    .ready (ready),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called at a negedge; returns with the accept edge number in acc.
  task automatic send(input logic [7:0] d, input logic p, input bit hold, input bit abort,
                      output int acc);
    int   n;
    exp_t e;
    n     = 0;
    data  = d;
    valid = 1'b1;
    while (ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", int'(n < 2000), 1);
    acc     = cyc + 1;
    e.d     = d;
    e.p     = p;
    e.acc   = acc;
    e.abort = abort;
    e.frame = HasPar ? {1'b1, p, d, 1'b0} : {2'b01, d, 1'b0};
    sb.push_back(e);
    @(negedge clk);
    if (!hold) valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_active) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(n < 5000), 1);
  endtask

  // Line monitor: decodes every frame and checks timing, bit stability and busy.
  initial begin : monitor
    exp_t        e;
    logic [10:0] bits;
    bit          stable;
    wait (rst === 1'b1);
    forever begin
      do @(negedge clk); while (tx !== 1'b0);
      mon_active = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_frame", 1, 0);
        repeat (NBits * Rate + 1) @(negedge clk);
      end else begin
        e      = sb.pop_front();
        bits   = '0;
        stable = 1'b1;
        check("start_time", cyc, e.acc + 1);
        for (int b = 0; b < (e.abort ? 4 : NBits); b++) begin
          for (int j = 0; j < Rate; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (j == 0) bits[b] = tx;
            else if (tx !== bits[b]) stable = 1'b0;
          end
        end
        check("bit_stable", int'(stable), 1);
        check("start_bit", int'(bits[0]), 0);
        if (e.abort) begin
          check("abort_bits", int'(bits[3:1]), int'(e.d[2:0]));
          wait (rst === 1'b0);
          wait (rst === 1'b1);
          @(negedge clk);
        end else begin
          check("data", int'(bits[8:1]), int'(e.d));
          check("frame", int'(bits), int'(e.frame));
          check("busy_end", int'(busy), 1);
          @(negedge clk);
          check("busy_fall", int'(busy), 0);
          check("idle_tx", int'(tx), 1);
        end
      end
      mon_active = 1'b0;
    end
  end

  initial begin : stim
    int acc;
    rst   = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    repeat (5) begin
      @(negedge clk);
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_ready", int'(ready), 1);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single frames; parity bits are hand-computed (even parity).
    send(8'hA5, 1'b0, 1'b0, 1'b0, acc);
    wait_idle();
    send(8'h07, 1'b1, 1'b0, 1'b0, acc);
    wait_idle();

    // Back-to-back with valid held: monitor enforces the 1-cycle idle gap.
    send(8'h55, 1'b0, 1'b1, 1'b0, acc);
    send(8'hAA, 1'b0, 1'b0, 1'b0, acc);
    wait_idle();

    // Mid-frame data change and valid pulse must not disturb or queue.
    send(8'hC3, 1'b0, 1'b0, 1'b0, acc);
    repeat (30) @(negedge clk);
    data  = 8'h00;
    valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_mid_frame", int'(ready), 0);
    valid = 1'b0;
    data  = 8'hFF;
    wait_idle();
    repeat (20) @(negedge clk);
    check("no_second_accept", int'(busy), 0);

    // Reset coincident with valid: nothing accepted.
    rst   = 1'b0;
    valid = 1'b1;
    data  = 8'h81;
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid_busy", int'(busy), 0);
    check("rst_valid_tx", int'(tx), 1);

    // Reset during data bit 3 (a 0 bit for 0x75), then a clean 0x3C frame.
    send(8'h75, 1'b1, 1'b0, 1'b1, acc);
    while (cyc < acc + 44) @(negedge clk);
    check("pre_abort_tx", int'(tx), 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(ready), 1);
    rst = 1'b1;
    wait_idle();
    send(8'h3C, 1'b0, 1'b0, 1'b0, acc);
    wait_idle();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
